// File: rtl/spi_pkg.sv
// Shared SPI definitions: byte and bit-counter widths, and the peripheral-side state encoding.
`timescale 1ns/1ps
package spi_pkg;
  localparam int SPI_BYTE_W    = 8;
  localparam int SPI_BIT_CNT_W = 3;

  typedef enum logic {SPI_IDLE, SPI_ACTIVE} spi_slv_state_t;
endpackage

// File: rtl/spi_sync.sv
// Single-bit multi-flop synchronizer with a configurable reset value.
`timescale 1ns/1ps
module spi_sync #(
  parameter int   STAGES  = 2,
  parameter logic RST_VAL = 1'b0
) (
  input  logic i_clk,
  input  logic i_rst_n,
  input  logic i_d,
  output logic o_q
);
  logic [STAGES-1:0] sync_q;
  logic [STAGES-1:0] sync_d;

  always_comb begin
    sync_d = {sync_q[STAGES-2:0], i_d};
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      sync_q <= {STAGES{RST_VAL}};
    end else begin
      sync_q <= sync_d;
    end
  end

  assign o_q = sync_q[STAGES-1];
endmodule

// File: rtl/spi_slave.sv
// Mode-0 MSB-first SPI peripheral; SPI pins oversampled in i_clk, one-entry TX holding register.
`timescale 1ns/1ps
module spi_slave
  import spi_pkg::*;
#(
  parameter int                    SYNC_STAGES     = 2,
  parameter logic [SPI_BYTE_W-1:0] DEFAULT_TX_BYTE = 8'hFF
) (
  input  logic                  i_clk,
  input  logic                  i_rst_n,
  input  logic                  i_sclk,
  input  logic                  i_mosi,
  input  logic                  i_cs_n,
  output logic                  o_miso,
  output logic                  o_miso_oe,
  output logic                  o_rx_valid,
  output logic [SPI_BYTE_W-1:0] o_rx_byte,
  input  logic                  i_tx_valid,
  input  logic [SPI_BYTE_W-1:0] i_tx_byte,
  output logic                  o_tx_ready,
  output logic                  o_tx_underrun
);
  localparam logic [SPI_BIT_CNT_W-1:0] BIT_LAST = {SPI_BIT_CNT_W{1'b1}};

  logic sclk_s, mosi_s, cs_n_s;

  spi_sync #(.STAGES(SYNC_STAGES), .RST_VAL(1'b0)) u_sync_sclk (
    .i_clk(i_clk), .i_rst_n(i_rst_n), .i_d(i_sclk), .o_q(sclk_s)
  );
  spi_sync #(.STAGES(SYNC_STAGES), .RST_VAL(1'b0)) u_sync_mosi (
    .i_clk(i_clk), .i_rst_n(i_rst_n), .i_d(i_mosi), .o_q(mosi_s)
  );
  spi_sync #(.STAGES(SYNC_STAGES), .RST_VAL(1'b1)) u_sync_cs_n (
    .i_clk(i_clk), .i_rst_n(i_rst_n), .i_d(i_cs_n), .o_q(cs_n_s)
  );

  spi_slv_state_t          state_q, state_d;
  logic                    sclk_dly_q, sclk_dly_d;
  logic                    cs_n_dly_q, cs_n_dly_d;
  logic [SPI_BIT_CNT_W-1:0] bit_cnt_q, bit_cnt_d;
  logic [SPI_BYTE_W-1:0]   rx_shift_q, rx_shift_d;
  logic [SPI_BYTE_W-1:0]   tx_shift_q, tx_shift_d;
  logic [SPI_BYTE_W-1:0]   rx_byte_q, rx_byte_d;
  logic [SPI_BYTE_W-1:0]   hold_q, hold_d;
  logic                    hold_full_q, hold_full_d;
  logic                    rx_valid_q, rx_valid_d;
  logic                    underrun_q, underrun_d;
  logic                    miso_q, miso_d;

  logic sclk_rise, sclk_fall, cs_fall, cs_rise;
  logic load;

  assign sclk_rise = sclk_s & ~sclk_dly_q;
  assign sclk_fall = ~sclk_s & sclk_dly_q;
  assign cs_fall   = ~cs_n_s & cs_n_dly_q;
  assign cs_rise   = cs_n_s & ~cs_n_dly_q;

  always_comb begin
    state_d     = state_q;
    sclk_dly_d  = sclk_s;
    cs_n_dly_d  = cs_n_s;
    bit_cnt_d   = bit_cnt_q;
    rx_shift_d  = rx_shift_q;
    tx_shift_d  = tx_shift_q;
    rx_byte_d   = rx_byte_q;
    hold_d      = hold_q;
    hold_full_d = hold_full_q;
    rx_valid_d  = 1'b0;
    underrun_d  = 1'b0;
    miso_d      = miso_q;
    load        = 1'b0;

    // Writes only land on an empty register, so they never collide with a consume.
    if (i_tx_valid && !hold_full_q) begin
      hold_d      = i_tx_byte;
      hold_full_d = 1'b1;
    end

    case (state_q)
      SPI_IDLE: begin
        if (cs_fall) begin
          state_d   = SPI_ACTIVE;
          bit_cnt_d = '0;
          load      = 1'b1;
        end
      end
      SPI_ACTIVE: begin
        if (sclk_rise) begin
          rx_shift_d = {rx_shift_q[SPI_BYTE_W-2:0], mosi_s};
          bit_cnt_d  = bit_cnt_q + 1'b1;
          if (bit_cnt_q == BIT_LAST) begin
            rx_byte_d  = {rx_shift_q[SPI_BYTE_W-2:0], mosi_s};
            rx_valid_d = 1'b1;
          end
        end else if (sclk_fall && !cs_rise) begin
          if (bit_cnt_q != '0) begin
            tx_shift_d = {tx_shift_q[SPI_BYTE_W-2:0], 1'b0};
            miso_d     = tx_shift_q[SPI_BYTE_W-2];
          end else begin
            load = 1'b1;
          end
        end
        // Deselect wins over shifting but a byte completed in this cycle is still delivered.
        if (cs_rise) begin
          state_d   = SPI_IDLE;
          bit_cnt_d = '0;
          miso_d    = 1'b0;
        end
      end
      default: state_d = SPI_IDLE;
    endcase

    if (load) begin
      if (hold_full_q) begin
        tx_shift_d  = hold_q;
        miso_d      = hold_q[SPI_BYTE_W-1];
        hold_full_d = 1'b0;
      end else begin
        tx_shift_d = DEFAULT_TX_BYTE;
        miso_d     = DEFAULT_TX_BYTE[SPI_BYTE_W-1];
        underrun_d = 1'b1;
      end
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q     <= SPI_IDLE;
      sclk_dly_q  <= 1'b0;
      cs_n_dly_q  <= 1'b1;
      bit_cnt_q   <= '0;
      rx_shift_q  <= '0;
      tx_shift_q  <= '0;
      rx_byte_q   <= '0;
      hold_q      <= '0;
      hold_full_q <= 1'b0;
      rx_valid_q  <= 1'b0;
      underrun_q  <= 1'b0;
      miso_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      sclk_dly_q  <= sclk_dly_d;
      cs_n_dly_q  <= cs_n_dly_d;
      bit_cnt_q   <= bit_cnt_d;
      rx_shift_q  <= rx_shift_d;
      tx_shift_q  <= tx_shift_d;
      rx_byte_q   <= rx_byte_d;
      hold_q      <= hold_d;
      hold_full_q <= hold_full_d;
      rx_valid_q  <= rx_valid_d;
      underrun_q  <= underrun_d;
      miso_q      <= miso_d;
    end
  end

  assign o_miso        = miso_q;
  assign o_miso_oe     = (state_q == SPI_ACTIVE);
  assign o_rx_valid    = rx_valid_q;
  assign o_rx_byte     = rx_byte_q;
  assign o_tx_ready    = ~hold_full_q;
  assign o_tx_underrun = underrun_q;
endmodule

// File: tb/tb_spi_slave.sv
// Directed bench for spi_slave: the bench plays the mode-0 master at 6 i_clk cycles per SCLK half-bit.
`timescale 1ns/1ps
module tb_spi_slave;
  localparam int HALF = 60;

  logic       i_clk = 1'b0;
  logic       i_rst_n = 1'b0;
  logic       i_sclk = 1'b0;
  logic       i_mosi = 1'b0;
  logic       i_cs_n = 1'b1;
  logic       i_tx_valid = 1'b0;
  logic [7:0] i_tx_byte = 8'h00;
  logic       o_miso, o_miso_oe, o_rx_valid, o_tx_ready, o_tx_underrun;
  logic [7:0] o_rx_byte;

  int tests = 0;
  int fails = 0;
  int rx_n = 0;
  int ur_n = 0;
  logic [7:0] rx_bytes[$];
  logic [7:0] m1, m2;

  spi_slave #(.SYNC_STAGES(2), .DEFAULT_TX_BYTE(8'hFF)) dut (
    .i_clk(i_clk), .i_rst_n(i_rst_n), .i_sclk(i_sclk), .i_mosi(i_mosi), .i_cs_n(i_cs_n),
    .o_miso(o_miso), .o_miso_oe(o_miso_oe), .o_rx_valid(o_rx_valid), .o_rx_byte(o_rx_byte),
    .i_tx_valid(i_tx_valid), .i_tx_byte(i_tx_byte), .o_tx_ready(o_tx_ready),
    .o_tx_underrun(o_tx_underrun)
  );

  always #5 i_clk = ~i_clk;

  // Every cycle a strobe is high counts as one pulse, so a stretched strobe shows up as extra bytes.
  always @(posedge i_clk) begin
    if (o_rx_valid) begin
      rx_n++;
      rx_bytes.push_back(o_rx_byte);
    end
    if (o_tx_underrun) ur_n++;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [7:0] rxb(input int i);
    return (i < rx_bytes.size()) ? rx_bytes[i] : 8'hxx;
  endfunction

  task automatic clear_mon();
    @(negedge i_clk);
    rx_n = 0;
    ur_n = 0;
    rx_bytes.delete();
  endtask

  task automatic wait_ready(input string tag);
    int n = 0;
    while (!o_tx_ready && n < 100) begin
      @(negedge i_clk);
      n++;
    end
    chk(tag, {31'd0, o_tx_ready}, 32'd1);
  endtask

  task automatic tx_write(input logic [7:0] b);
    @(negedge i_clk);
    i_tx_valid = 1'b1;
    i_tx_byte  = b;
    @(negedge i_clk);
    i_tx_valid = 1'b0;
  endtask

  // Bits 7..0; MISO sampled at each rise. The last byte of a frame raises CS before SCLK falls.
  task automatic xfer_byte(input logic [7:0] tx, input bit last, output logic [7:0] rx);
    for (int i = 7; i >= 0; i--) begin
      i_mosi = tx[i];
      #(HALF);
      i_sclk = 1'b1;
      rx[i] = o_miso;
      #(HALF);
      if (i == 0 && last) begin
        i_cs_n = 1'b1;
        #(HALF);
      end
      i_sclk = 1'b0;
    end
  endtask

  initial begin
    #1;
    chk("rst_miso", {31'd0, o_miso}, 32'd0);
    chk("rst_oe", {31'd0, o_miso_oe}, 32'd0);
    chk("rst_rx_valid", {31'd0, o_rx_valid}, 32'd0);
    chk("rst_rx_byte", {24'd0, o_rx_byte}, 32'd0);
    chk("rst_tx_ready", {31'd0, o_tx_ready}, 32'd1);
    chk("rst_underrun", {31'd0, o_tx_underrun}, 32'd0);
    repeat (3) @(negedge i_clk);
    i_rst_n = 1'b1;
    repeat (5) @(negedge i_clk);

    // 1: preloaded A5, master sends 3E
    tx_write(8'hA5);
    chk("t1_ready_low", {31'd0, o_tx_ready}, 32'd0);
    clear_mon();
    i_cs_n = 1'b0;
    xfer_byte(8'h3E, 1'b1, m1);
    repeat (20) @(negedge i_clk);
    chk("t1_miso", {24'd0, m1}, 32'hA5);
    chk("t1_rx_n", rx_n, 1);
    chk("t1_rx_byte", {24'd0, rxb(0)}, 32'h3E);
    chk("t1_ready", {31'd0, o_tx_ready}, 32'd1);
    chk("t1_underrun", ur_n, 0);

    // 2: nothing preloaded, master sends 00
    clear_mon();
    i_cs_n = 1'b0;
    xfer_byte(8'h00, 1'b1, m1);
    repeat (20) @(negedge i_clk);
    chk("t2_miso", {24'd0, m1}, 32'hFF);
    chk("t2_underrun", ur_n, 1);
    chk("t2_rx_n", rx_n, 1);
    chk("t2_rx_byte", {24'd0, o_rx_byte}, 32'h00);

    // 3: two bytes under one CS, second TX byte written mid-byte
    tx_write(8'h11);
    clear_mon();
    i_cs_n = 1'b0;
    fork
      xfer_byte(8'hC3, 1'b0, m1);
      begin
        wait_ready("t3_ready_rise");
        tx_write(8'h22);
      end
    join
    xfer_byte(8'h5A, 1'b1, m2);
    repeat (20) @(negedge i_clk);
    chk("t3_miso0", {24'd0, m1}, 32'h11);
    chk("t3_miso1", {24'd0, m2}, 32'h22);
    chk("t3_rx_n", rx_n, 2);
    chk("t3_rx0", {24'd0, rxb(0)}, 32'hC3);
    chk("t3_rx1", {24'd0, rxb(1)}, 32'h5A);
    chk("t3_underrun", ur_n, 0);

    // 4: abort after 4 bits, then a full byte
    clear_mon();
    i_cs_n = 1'b0;
    for (int i = 7; i >= 4; i--) begin
      i_mosi = i[0] ? 1'b1 : 1'b1;
      #(HALF);
      i_sclk = 1'b1;
      #(HALF);
      i_sclk = 1'b0;
    end
    chk("t4_oe_active", {31'd0, o_miso_oe}, 32'd1);
    i_cs_n = 1'b1;
    repeat (10) @(negedge i_clk);
    chk("t4_oe_idle", {31'd0, o_miso_oe}, 32'd0);
    chk("t4_no_strobe", rx_n, 0);
    i_cs_n = 1'b0;
    xfer_byte(8'h81, 1'b1, m1);
    repeat (20) @(negedge i_clk);
    chk("t4_rx_n", rx_n, 1);
    chk("t4_rx_byte", {24'd0, rxb(0)}, 32'h81);
    chk("t4_oe_after", {31'd0, o_miso_oe}, 32'd0);

    // 5: reset after 3 bits with the holding register full
    tx_write(8'h33);
    i_cs_n = 1'b0;
    wait_ready("t5_ready_rise");
    tx_write(8'h44);
    for (int i = 0; i < 3; i++) begin
      i_mosi = 1'b1;
      #(HALF);
      i_sclk = 1'b1;
      #(HALF);
      i_sclk = 1'b0;
    end
    chk("t5_full", {31'd0, o_tx_ready}, 32'd0);
    i_rst_n = 1'b0;
    #1;
    chk("t5_rst_miso", {31'd0, o_miso}, 32'd0);
    chk("t5_rst_oe", {31'd0, o_miso_oe}, 32'd0);
    chk("t5_rst_rx_byte", {24'd0, o_rx_byte}, 32'd0);
    chk("t5_rst_ready", {31'd0, o_tx_ready}, 32'd1);
    chk("t5_rst_underrun", {31'd0, o_tx_underrun}, 32'd0);
    i_cs_n = 1'b1;
    repeat (3) @(negedge i_clk);
    i_rst_n = 1'b1;
    repeat (5) @(negedge i_clk);
    clear_mon();
    i_cs_n = 1'b0;
    xfer_byte(8'h7E, 1'b1, m1);
    repeat (20) @(negedge i_clk);
    chk("t5_miso", {24'd0, m1}, 32'hFF);
    chk("t5_rx_n", rx_n, 1);
    chk("t5_rx_byte", {24'd0, rxb(0)}, 32'h7E);
    chk("t5_underrun", ur_n, 1);

    // 6: write lands in the same cycle as the CS-fall load on an empty register
    chk("t6_ready_pre", {31'd0, o_tx_ready}, 32'd1);
    clear_mon();
    i_cs_n = 1'b0;
    @(negedge i_clk);
    @(negedge i_clk);
    i_tx_valid = 1'b1;
    i_tx_byte  = 8'h96;
    @(negedge i_clk);
    i_tx_valid = 1'b0;
    chk("t6_underrun_now", ur_n, 0);
    xfer_byte(8'hAA, 1'b0, m1);
    xfer_byte(8'h55, 1'b1, m2);
    repeat (20) @(negedge i_clk);
    chk("t6_miso0", {24'd0, m1}, 32'hFF);
    chk("t6_miso1", {24'd0, m2}, 32'h96);
    chk("t6_underrun", ur_n, 1);
    chk("t6_rx0", {24'd0, rxb(0)}, 32'hAA);
    chk("t6_rx1", {24'd0, rxb(1)}, 32'h55);
    chk("t6_ready_end", {31'd0, o_tx_ready}, 32'd1);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
